regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//   Shares the register file's single write port between two writeback sources (req0 = ALU, req1 = load unit).
//   Round-robin arbitration over valid/ready handshakes feeds a one-entry registered write stage, which drives
//   the regfile write port (writeReg/writeData/write). Writes to x0 are dropped.
//   Flags read-after-write hazards for the two read ports against the staged write.
// PARAMETERS
//   AW   5    register address width (32 registers)
//   DW   32   data width
// PORTS
//   clk          in   1    clock; all state updates on posedge
//   rst_n        in   1    asynchronous active-low reset
//   req0_valid   in   1    requester 0 has a write
//   req0_addr    in   AW   requester 0 destination register
//   req0_data    in   DW   requester 0 write data
//   req0_ready   out  1    requester 0 accepted this cycle when valid&ready
//   req1_valid/req1_addr/req1_data/req1_ready    same as req0, requester 1
//   hold         in   1    pipeline freeze; staged write neither issues nor is replaced
//   wr_en        out  1    to regfile write
//   wr_addr      out  AW   to regfile writeReg
//   wr_data      out  DW   to regfile writeData
//   rd_addr_a    in   AW   regfile readReg1 address, for hazard check
//   rd_addr_b    in   AW   regfile readReg2 address
//   hazard_a     out  1    read port A conflicts with staged write
//   hazard_b     out  1    read port B conflicts with staged write
//   fwd_valid_a/fwd_valid_b  out 1   forwarding hit (REGFILE_FWD_EN only)
//   fwd_data_a/fwd_data_b    out DW  forwarded data (REGFILE_FWD_EN only)
// BEHAVIOUR
//   - Reset (async, rst_n=0): stage_valid=0, stg_addr=0, stg_data=0, rr_ptr=0 (req0 preferred); outputs all 0.
//   - Grant (comb.): only one valid -> that one; both valid -> requester rr_ptr; none -> no grant.
//   - space = !stage_valid | !hold. reqK_ready = grantK & space. Ready is never asserted to a non-granted requester.
//   - Accept = granted valid & space. Posedge: stage loads {addr,data}, stage_valid=1,
//     rr_ptr = index of other requester. No accept & !hold: stage_valid=0. No accept & hold: stage unchanged.
//   - rr_ptr changes only on accept; a lone requester does not move priority to the idle one beyond that rule.
//   - Latency: accepted at edge N -> wr_en high during cycle N+1 (regfile writes at edge N+1), unless hold.
//   - wr_en = stage_valid & !hold & (stg_addr != 0); wr_addr=stg_addr, wr_data=stg_data (registered, no comb. path
//     from requesters). An x0 write is accepted and retires normally but never asserts wr_en.
//   - Throughput: one accept per cycle when hold=0; back-to-back accepts alternate when both requesters stay valid.
//   - hazard_x = stage_valid & (stg_addr != 0) & (stg_addr == rd_addr_x), independent of hold.
//   - Both requesters writing same address: serialized in grant order; last accepted wins in the regfile.
//   - Reset mid-operation: staged write discarded, not issued; requesters must re-present.
// CONFIGURATION
//   REGFILE_FWD_EN defined: fwd_valid_x = the hazard_x condition; fwd_data_x = stg_data; hazard_x forced 0
//     (consumer muxes fwd_data over regfile readData).
//   REGFILE_FWD_EN undefined: fwd_valid_x=0, fwd_data_x=0; hazard_x as above; no forwarding muxes built.
// TESTING
//   1 Reset: assert rst_n=0 mid-stream with stage_valid=1 -> wr_en=0, wr_addr=0, all readies 0, no write issued.
//   2 Single: req0 {x5,0xDEADBEEF} valid 1 cycle -> req0_ready=1 same cycle; next cycle wr_en=1, wr_addr=5.
//   3 Contention: both valid 4 cycles, req0 x1/0x11, req1 x2/0x22 -> grants 0,1,0,1; wr_addr 1,2,1,2 one cycle later.
//   4 x0: req1 {x0,0xFFFFFFFF} -> req1_ready=1, wr_en stays 0 throughout, hazard_a=0 with rd_addr_a=0.
//   5 Hold: stage holds x7; hold=1 3 cycles with req0 valid -> wr_en=0, req0_ready=0, stage kept; hold=0 -> x7 written.
//   6 Hazard: stage x9/0x1234, rd_addr_a=9, rd_addr_b=3 -> hazard_a=1, hazard_b=0; with REGFILE_FWD_EN:
//     hazard_a=0, fwd_valid_a=1, fwd_data_a=0x1234.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Shares the register file's single write port between two
//               writeback sources (req0 = ALU, req1 = load unit). A
//               round-robin arbiter over valid/ready handshakes feeds a
//               one-entry registered write stage that drives the regfile
//               write port. Writes to x0 are accepted but never issued.
//               Read-after-write hazards against the staged write are
//               flagged for both regfile read ports.
// Options     : REGFILE_FWD_EN - when defined, the staged write is forwarded
//               to the read ports (fwd_valid_x/fwd_data_x) and hazard_x is
//               held low. When undefined, hazards are flagged and the
//               forwarding outputs are tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
   parameter int AW = 5,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   // requester 0 (ALU)
   input  logic          req0_valid,
   input  logic [AW-1:0] req0_addr,
   input  logic [DW-1:0] req0_data,
   output logic          req0_ready,
   // requester 1 (load unit)
   input  logic          req1_valid,
   input  logic [AW-1:0] req1_addr,
   input  logic [DW-1:0] req1_data,
   output logic          req1_ready,
   // pipeline freeze
   input  logic          hold,
   // regfile write port
   output logic          wr_en,
   output logic [AW-1:0] wr_addr,
   output logic [DW-1:0] wr_data,
   // regfile read addresses for hazard detection
   input  logic [AW-1:0] rd_addr_a,
   input  logic [AW-1:0] rd_addr_b,
   output logic          hazard_a,
   output logic          hazard_b,
   // forwarding (active only with REGFILE_FWD_EN)
   output logic          fwd_valid_a,
   output logic          fwd_valid_b,
   output logic [DW-1:0] fwd_data_a,
   output logic [DW-1:0] fwd_data_b
);

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   logic          r_stage_valid;
   logic [AW-1:0] r_stg_addr;
   logic [DW-1:0] r_stg_data;
   logic          r_rr_ptr;     // 0: req0 preferred on contention, 1: req1

   // -------------------------------------------------------------------------
   // Combinational arbitration
   // -------------------------------------------------------------------------
   logic          w_grant0;
   logic          w_grant1;
   logic          w_space;
   logic          w_accept;
   logic [AW-1:0] w_sel_addr;
   logic [DW-1:0] w_sel_data;
   logic          w_stg_nonzero;
   logic          w_hit_a;
   logic          w_hit_b;

   // Round-robin grant: a lone requester always wins; on contention rr_ptr decides.
   always_comb begin
      w_grant0 = 1'b0;
      w_grant1 = 1'b0;
      if (req0_valid && req1_valid) begin
         w_grant0 = (r_rr_ptr == 1'b0);
         w_grant1 = (r_rr_ptr == 1'b1);
      end else begin
         w_grant0 = req0_valid;
         w_grant1 = req1_valid;
      end
   end

   // The stage can take a new entry if it is empty or is retiring this cycle.
   // Readies are gated by rst_n so every output reads zero while in reset,
   // even if a requester keeps its valid high across the reset.
   assign w_space    = !r_stage_valid || !hold;
   assign req0_ready = w_grant0 && w_space && rst_n;
   assign req1_ready = w_grant1 && w_space && rst_n;
   assign w_accept   = req0_ready || req1_ready;

   // Select the payload of whichever requester holds the grant.
   always_comb begin
      w_sel_addr = req0_addr;
      w_sel_data = req0_data;
      if (w_grant1) begin
         w_sel_addr = req1_addr;
         w_sel_data = req1_data;
      end
   end

   // -------------------------------------------------------------------------
   // Write stage and round-robin pointer
   // -------------------------------------------------------------------------
   // Load on accept, drain when not frozen, otherwise keep the staged write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stage_valid <= 1'b0;
         r_stg_addr    <= '0;
         r_stg_data    <= '0;
         r_rr_ptr      <= 1'b0;
      end else if (w_accept) begin
         r_stage_valid <= 1'b1;
         r_stg_addr    <= w_sel_addr;
         r_stg_data    <= w_sel_data;
         // Priority passes to the requester that did not just win.
         r_rr_ptr      <= w_grant0;
      end else if (!hold) begin
         r_stage_valid <= 1'b0;
      end
   end

   // -------------------------------------------------------------------------
   // Regfile write port (purely from registered state)
   // -------------------------------------------------------------------------
   assign w_stg_nonzero = (r_stg_addr != '0);
   assign wr_en         = r_stage_valid && !hold && w_stg_nonzero;
   assign wr_addr       = r_stg_addr;
   assign wr_data       = r_stg_data;

   // -------------------------------------------------------------------------
   // Read-after-write detection; x0 never conflicts since it is never written.
   // Deliberately independent of hold: a frozen staged write is still pending.
   // -------------------------------------------------------------------------
   assign w_hit_a = r_stage_valid && w_stg_nonzero && (r_stg_addr == rd_addr_a);
   assign w_hit_b = r_stage_valid && w_stg_nonzero && (r_stg_addr == rd_addr_b);

`ifdef REGFILE_FWD_EN
   // Consumer muxes fwd_data over regfile readData, so no stall is needed.
   assign fwd_valid_a = w_hit_a;
   assign fwd_valid_b = w_hit_b;
   assign fwd_data_a  = r_stg_data;
   assign fwd_data_b  = r_stg_data;
   assign hazard_a    = 1'b0;
   assign hazard_b    = 1'b0;
`else
   // No forwarding path: the consumer must stall on hazard.
   assign fwd_valid_a = 1'b0;
   assign fwd_valid_b = 1'b0;
   assign fwd_data_a  = '0;
   assign fwd_data_b  = '0;
   assign hazard_a    = w_hit_a;
   assign hazard_b    = w_hit_b;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Self-checking bench for regfile_wb_arbiter. A reference model
//               predicts grants, readies, wr_en and hazards each cycle; the
//               expected regfile writes go into a scoreboard queue when the
//               model accepts and are popped when the DUT raises wr_en.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

   localparam int AW = 5;
   localparam int DW = 32;

   logic          clk;
   logic          rst_n;
   logic          req0_valid, req1_valid;
   logic [AW-1:0] req0_addr,  req1_addr;
   logic [DW-1:0] req0_data,  req1_data;
   logic          req0_ready, req1_ready;
   logic          hold;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic [AW-1:0] rd_addr_a, rd_addr_b;
   logic          hazard_a, hazard_b;
   logic          fwd_valid_a, fwd_valid_b;
   logic [DW-1:0] fwd_data_a, fwd_data_b;

   regfile_wb_arbiter #(.AW(AW), .DW(DW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_addr  (req0_addr),
      .req0_data  (req0_data),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_addr  (req1_addr),
      .req1_data  (req1_data),
      .req1_ready (req1_ready),
      .hold       (hold),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .rd_addr_a  (rd_addr_a),
      .rd_addr_b  (rd_addr_b),
      .hazard_a   (hazard_a),
      .hazard_b   (hazard_b),
      .fwd_valid_a(fwd_valid_a),
      .fwd_valid_b(fwd_valid_b),
      .fwd_data_a (fwd_data_a),
      .fwd_data_b (fwd_data_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic          m_sv;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data;
   logic          m_rr;
   logic [AW+DW-1:0] sb_q[$];

   // Snapshots of DUT outputs taken at the last negedge
   logic          s_r0, s_r1, s_wr_en, s_hz_a, s_hz_b, s_fv_a;
   logic [AW-1:0] s_wr_addr;
   logic [DW-1:0] s_fd_a;
   logic [3:0]    grant_seq;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_sv   = 1'b0;
      m_addr = '0;
      m_data = '0;
      m_rr   = 1'b0;
      sb_q.delete();
   endtask

   // One clock: check outputs at negedge against the model, update model at posedge.
   task automatic step();
      logic g0, g1, sp, e_r0, e_r1, e_wr, hit_a, hit_b;
      logic [AW+DW-1:0] exp_w;
      @(negedge clk);
      g0    = req0_valid && (!req1_valid || (m_rr == 1'b0));
      g1    = req1_valid && (!req0_valid || (m_rr == 1'b1));
      sp    = !m_sv || !hold;
      e_r0  = g0 && sp && rst_n;
      e_r1  = g1 && sp && rst_n;
      e_wr  = m_sv && !hold && (m_addr != 0);
      hit_a = m_sv && (m_addr != 0) && (m_addr == rd_addr_a);
      hit_b = m_sv && (m_addr != 0) && (m_addr == rd_addr_b);
      s_r0 = req0_ready; s_r1 = req1_ready; s_wr_en = wr_en; s_wr_addr = wr_addr;
      s_hz_a = hazard_a; s_hz_b = hazard_b; s_fv_a = fwd_valid_a; s_fd_a = fwd_data_a;
      check_val("req0_ready", req0_ready, e_r0);
      check_val("req1_ready", req1_ready, e_r1);
      check_val("wr_en", wr_en, e_wr);
`ifdef REGFILE_FWD_EN
      check_val("hazard_a", hazard_a, 1'b0);
      check_val("hazard_b", hazard_b, 1'b0);
      check_val("fwd_valid_a", fwd_valid_a, hit_a);
      check_val("fwd_valid_b", fwd_valid_b, hit_b);
      if (hit_a) check_val("fwd_data_a", fwd_data_a, m_data);
      if (hit_b) check_val("fwd_data_b", fwd_data_b, m_data);
`else
      check_val("hazard_a", hazard_a, hit_a);
      check_val("hazard_b", hazard_b, hit_b);
      check_val("fwd_valid_a", fwd_valid_a, 1'b0);
      check_val("fwd_data_b", fwd_data_b, '0);
`endif
      if (wr_en === 1'b1) begin
         if (sb_q.size() == 0) begin
            check_val("sb_unexpected_write", {wr_addr, wr_data}, '0);
         end else begin
            exp_w = sb_q.pop_front();
            check_val("wr_addr", wr_addr, exp_w[AW+DW-1:DW]);
            check_val("wr_data", wr_data, exp_w[DW-1:0]);
         end
      end
      @(posedge clk);
      if (!rst_n) begin
         model_reset();
      end else if (e_r0 || e_r1) begin
         m_sv   = 1'b1;
         m_addr = e_r1 ? req1_addr : req0_addr;
         m_data = e_r1 ? req1_data : req0_data;
         m_rr   = e_r0;
         if (m_addr != 0) sb_q.push_back({m_addr, m_data});
      end else if (!hold) begin
         m_sv = 1'b0;
      end
      #1;
   endtask

   task automatic idle_inputs();
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_addr = '0; req1_addr = '0; req0_data = '0; req1_data = '0;
      hold = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      rd_addr_a = '0; rd_addr_b = '0;
      model_reset();
      #2;
      // Reset state
      check_val("rst_wr_en", wr_en, 1'b0);
      check_val("rst_wr_addr", wr_addr, '0);
      check_val("rst_wr_data", wr_data, '0);
      step(); step();
      rst_n = 1'b1;
      step();

      // Single write from req0, ready in the same cycle, written next cycle
      req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
      step();
      check_val("single_ready", s_r0, 1'b1);
      idle_inputs();
      step();
      check_val("single_wr_en", s_wr_en, 1'b1);
      check_val("single_wr_addr", s_wr_addr, 5'd5);

      // x0 write from req1: accepted, never issued, no hazard on rd_addr_a=0
      rd_addr_a = '0;
      req1_valid = 1'b1; req1_addr = '0; req1_data = 32'hFFFFFFFF;
      step();
      check_val("x0_ready", s_r1, 1'b1);
      idle_inputs();
      step();
      check_val("x0_wr_en", s_wr_en, 1'b0);
      check_val("x0_hazard_a", s_hz_a, 1'b0);

      // Contention: grants alternate 0,1,0,1 (priority is back on req0 here)
      grant_seq = '0;
      req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h11;
      req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'h22;
      for (int i = 0; i < 4; i++) begin
         step();
         grant_seq = {grant_seq[2:0], s_r1};
      end
      check_val("contention_grants", grant_seq, 4'b0101);
      idle_inputs();
      step();
      check_val("contention_last_addr", s_wr_addr, 5'd2);

      // Hold: x7 staged, frozen for 3 cycles with req0 still valid
      req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h77;
      step();
      req0_addr = 5'd8; req0_data = 32'h88; hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check_val("hold_wr_en", s_wr_en, 1'b0);
         check_val("hold_ready", s_r0, 1'b0);
         check_val("hold_stage_addr", s_wr_addr, 5'd7);
      end
      hold = 1'b0;
      step();
      check_val("hold_release_wr_en", s_wr_en, 1'b1);
      check_val("hold_release_addr", s_wr_addr, 5'd7);
      idle_inputs();
      step();

      // Hazard on a frozen staged x9
      req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h1234;
      step();
      idle_inputs();
      hold = 1'b1; rd_addr_a = 5'd9; rd_addr_b = 5'd3;
      step();
`ifdef REGFILE_FWD_EN
      check_val("hz_fwd_hazard_a", s_hz_a, 1'b0);
      check_val("hz_fwd_valid_a", s_fv_a, 1'b1);
      check_val("hz_fwd_data_a", s_fd_a, 32'h1234);
`else
      check_val("hz_hazard_a", s_hz_a, 1'b1);
      check_val("hz_hazard_b", s_hz_b, 1'b0);
`endif
      hold = 1'b0;
      step();
      rd_addr_a = '0; rd_addr_b = '0;

      // Reset mid-stream with a staged write: discarded, never issued
      req0_valid = 1'b1; req0_addr = 5'd12; req0_data = 32'hC0FFEE;
      step();
      rst_n = 1'b0;
      #2;
      model_reset();
      check_val("midrst_wr_en", wr_en, 1'b0);
      check_val("midrst_wr_addr", wr_addr, '0);
      check_val("midrst_req0_ready", req0_ready, 1'b0);
      check_val("midrst_req1_ready", req1_ready, 1'b0);
      step(); step();
      rst_n = 1'b1;
      step();
      idle_inputs();
      step(); step();

      // Randomised traffic against the model
      for (int i = 0; i < 300; i++) begin
         req0_valid = 1'($urandom_range(0, 1));
         req1_valid = 1'($urandom_range(0, 1));
         req0_addr  = AW'($urandom_range(0, 31));
         req1_addr  = AW'($urandom_range(0, 31));
         req0_data  = $urandom;
         req1_data  = $urandom;
         hold       = ($urandom_range(0, 3) == 0);
         rd_addr_a  = AW'($urandom_range(0, 31));
         rd_addr_b  = m_addr;
         step();
      end
      idle_inputs();
      step(); step(); step();
      check_val("sb_drained", sb_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
